addr_trans_mc: RTL and testbench
================================

# addr_trans_mc

Multi-channel, parametrised address translation unit between the fetch/LSU request ports and the cache/bus interface. Each of NUM_CH channels accepts a virtual address on a valid/ready handshake and returns a registered physical address with an uncached flag. It supports three translation paths: direct-address mode, the two direct-map windows DMW0/DMW1, and page-mapped lookup through a shared, arbitrated TLB query port.

## Interface
- NUM_CH, default 2: number of independent translation channels (1..4); channel 0 is fetch by convention.
- PG_W, default 12: page-offset width; PPN/VPN width is 32-PG_W.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- csr_da, csr_pg  in  1 each  CRMD.DA / CRMD.PG.
- csr_plv  in  2  current privilege level.
- csr_dmw0, csr_dmw1  in  32 each  DMW CSRs. Fields: [31:29] VSEG, [27:25] PSEG, [5:4] MAT, [3] PLV3, [0] PLV0.
- csr_dat  in  NUM_CH*2  per-channel DA-mode MAT (DATF for fetch, DATM for data).
- req_valid, req_ready  in/out  NUM_CH  request handshake.
- req_vaddr  in  NUM_CH*32  virtual addresses.
- rsp_valid, rsp_ready  out/in  NUM_CH  response handshake.
- rsp_paddr  out  NUM_CH*32; rsp_uncached, rsp_fault  out  NUM_CH.
- tlb_req_valid, tlb_req_ready  out/in  1  TLB query handshake.
- tlb_req_vpn  out  32-PG_W; tlb_req_ch  out  max(1,$clog2(NUM_CH)).
- tlb_rsp_valid, tlb_rsp_hit  in  1; tlb_rsp_ppn  in  32-PG_W; tlb_rsp_mat  in  2.

## Operation
- Mode is sampled at request accept:
  - csr_da=1 → direct.
  - csr_da=0 and csr_pg=1 → mapped.
  - Any other combination → direct.
- Direct: paddr = vaddr; uncached = (csr_dat[ch] == 2'b00).
- Mapped:
  - DMWn hits when vaddr[31:29]==VSEG and the PLV bit for csr_plv is set (plv 0 → bit 0, plv 3 → bit 3, plv 1/2 → never).
  - DMW0 has priority over DMW1.
  - On a hit: paddr = {PSEG, vaddr[28:0]}; uncached = (MAT == 0).
- Mapped with no DMW hit: TLB query with VPN = vaddr[31:PG_W].
  - tlb_rsp_hit=1 → paddr = {ppn, vaddr[PG_W-1:0]}, uncached = (tlb_rsp_mat == 0), fault = 0.
  - tlb_rsp_hit=0 → fault = 1, paddr = 0, uncached = 0.
- Per-channel FSM:
  - IDLE: accept → RESP for direct or DMW hit; accept → TLB_REQ otherwise.
  - TLB_REQ: on grant with tlb_req_ready → TLB_WAIT.
  - TLB_WAIT: tlb_rsp_valid → RESP.
  - RESP: hold outputs until rsp_ready; then → IDLE, or accept a new request in the same cycle.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready).
- TLB arbitration:
  - Round-robin among channels in TLB_REQ; pointer advances past the granted channel.
  - One outstanding query at most; tlb_req_valid is low while one is outstanding.
  - Responses are matched to the outstanding tlb_req_ch.
- Request VPN and sampled CSR values are held in per-channel registers; CSR changes after accept do not affect an in-flight request.

## Timing
- Reset values:
  - All FSMs IDLE; round-robin pointer 0; no outstanding query.
  - req_ready = all 1s; rsp_valid = 0; tlb_req_valid = 0.
  - rsp_paddr, rsp_uncached, rsp_fault, tlb_req_vpn, tlb_req_ch = 0.
- Direct/DMW latency: rsp_valid rises 1 cycle after accept. Throughput is 1 per cycle per channel with rsp_ready held high.
- TLB path latency: accept → tlb_req_valid next cycle → RESP the cycle after tlb_rsp_valid (minimum 3 cycles).
- tlb_req_valid/vpn/ch stay stable until tlb_req_ready.
- rsp_* stay stable while rsp_valid & !rsp_ready.
- tlb_rsp_valid with no query outstanding (for example after reset mid-query) is ignored.
- Reset asserted mid-operation aborts all channels immediately, with no response issued.

## Configuration
- ADDR_TRANS_PGMAP_EN defined: TLB path, arbiter and TLB_REQ/TLB_WAIT states are present.
- ADDR_TRANS_PGMAP_EN undefined:
  - Mapped-mode DMW misses go to RESP in 1 cycle with rsp_fault=1, paddr=0.
  - tlb_req_valid is tied 0; tlb_rsp_* inputs are ignored.

## Structure
- Package addr_trans_pkg holds:
  - channel state enum (IDLE, TLB_REQ, TLB_WAIT, RESP) and mode enum (DIRECT, MAPPED);
  - DMW field bit-position constants;
  - function dmw_match(vaddr, dmw, plv).
- Sub-module addr_trans_ch contains one channel FSM plus its registers and the combinational direct/DMW result. It is instantiated NUM_CH times via generate.
- The top level holds the round-robin arbiter and the outstanding-query tracking.

## Test plan
- DA mode: csr_da=1, csr_dat[0]=01, vaddr 0x1C00_0000 → next cycle rsp_paddr 0x1C00_0000, uncached 0, fault 0.
- Mapped, DMW0=0x9000_0011, plv 0, vaddr 0x9000_1234 → paddr 0x1000_1234, uncached 0, 1-cycle latency. Same request with plv 3 → TLB query issued with VPN 0x90001.
- Both channels miss in the same cycle (vaddr 0x0000_0678), ch1 response forced to hit=0:
  - ch0 is granted first; tlb_rsp hit, ppn 0x12345 → ch0 paddr 0x1234_5678.
  - ch1 is queried only after that response → fault=1.
- Backpressure: rsp_ready=0 for 3 cycles → rsp_* stable and req_ready=0. Raising rsp_ready together with req_valid accepts the next request in the same cycle.
- Reset pulsed during TLB_WAIT, then a stray tlb_rsp_valid → no rsp_valid, all req_ready=1.
- With ADDR_TRANS_PGMAP_EN undefined: mapped DMW miss → fault=1 after 1 cycle, tlb_req_valid never rises.

Source files
------------

// File: rtl/addr_trans_pkg.sv
// Shared types and DMW helpers for the multi-channel address translation unit.
// Optional page-mapped path is enabled by defining ADDR_TRANS_PGMAP_EN.
package addr_trans_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TLB_REQ  = 2'd1,
        TLB_WAIT = 2'd2,
        RESP     = 2'd3
    } ch_state_e;

    typedef enum logic {
        DIRECT = 1'b0,
        MAPPED = 1'b1
    } mode_e;

    localparam int DMW_VSEG_HI = 31;
    localparam int DMW_VSEG_LO = 29;
    localparam int DMW_PSEG_HI = 27;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_MAT_HI  = 5;
    localparam int DMW_MAT_LO  = 4;
    localparam int DMW_PLV3    = 3;
    localparam int DMW_PLV0    = 0;

    // Privilege levels 1 and 2 can never use a direct-map window.
    function automatic logic dmw_match(input logic [31:0] vaddr,
                                       input logic [31:0] dmw,
                                       input logic [1:0]  plv);
        logic plv_ok;
        case (plv)
            2'd0:    plv_ok = dmw[DMW_PLV0];
            2'd3:    plv_ok = dmw[DMW_PLV3];
            default: plv_ok = 1'b0;
        endcase
        return plv_ok && (vaddr[31:29] == dmw[DMW_VSEG_HI:DMW_VSEG_LO]);
    endfunction

endpackage

// File: rtl/addr_trans_ch.sv
// One translation channel: request FSM, held request, direct/DMW result and response registers.
// TLB_REQ/TLB_WAIT handling exists only when ADDR_TRANS_PGMAP_EN is defined.
module addr_trans_ch
    import addr_trans_pkg::*;
#(
    parameter int PG_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             csr_da,
    input  logic             csr_pg,
    input  logic [1:0]       csr_plv,
    input  logic [31:0]      csr_dmw0,
    input  logic [31:0]      csr_dmw1,
    input  logic [1:0]       csr_dat,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_vaddr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_paddr,
    output logic             rsp_uncached,
    output logic             rsp_fault,
    output logic             tlb_pend,
    output logic [31-PG_W:0] tlb_vpn,
    input  logic             tlb_grant,
    input  logic             tlb_done,
    input  logic             tlb_hit,
    input  logic [31-PG_W:0] tlb_ppn,
    input  logic [1:0]       tlb_mat
);

    ch_state_e   state;
    mode_e       acc_mode;
    logic        accept;
    logic        fast_done;
    logic [31:0] fast_paddr;
    logic        fast_uncached;
    logic        fast_fault;

    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign acc_mode  = (!csr_da && csr_pg) ? MAPPED : DIRECT;

    // Result for anything resolvable without the TLB, evaluated on the accept cycle.
    always_comb begin
        fast_done     = 1'b1;
        fast_paddr    = req_vaddr;
        fast_uncached = (csr_dat == 2'b00);
        fast_fault    = 1'b0;
        if (acc_mode == MAPPED) begin
            if (dmw_match(req_vaddr, csr_dmw0, csr_plv)) begin
                fast_paddr    = {csr_dmw0[DMW_PSEG_HI:DMW_PSEG_LO], req_vaddr[28:0]};
                fast_uncached = (csr_dmw0[DMW_MAT_HI:DMW_MAT_LO] == 2'b00);
            end else if (dmw_match(req_vaddr, csr_dmw1, csr_plv)) begin
                fast_paddr    = {csr_dmw1[DMW_PSEG_HI:DMW_PSEG_LO], req_vaddr[28:0]};
                fast_uncached = (csr_dmw1[DMW_MAT_HI:DMW_MAT_LO] == 2'b00);
            end else begin
                fast_paddr    = '0;
                fast_uncached = 1'b0;
                fast_fault    = 1'b1;
`ifdef ADDR_TRANS_PGMAP_EN
                fast_done     = 1'b0;
`endif
            end
        end
    end

`ifdef ADDR_TRANS_PGMAP_EN
    logic [31:0] vaddr_p0;

    always_ff @(posedge clk) begin
        if (accept) begin
            vaddr_p0 <= req_vaddr;
        end
    end

    assign tlb_pend = (state == TLB_REQ);
    assign tlb_vpn  = vaddr_p0[31:PG_W];
`else
    logic unused_tlb;

    assign tlb_pend   = 1'b0;
    assign tlb_vpn    = '0;
    assign unused_tlb = ^{tlb_grant, tlb_done, tlb_hit, tlb_ppn, tlb_mat};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rsp_paddr    <= '0;
            rsp_uncached <= 1'b0;
            rsp_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (fast_done) begin
                            state        <= RESP;
                            rsp_paddr    <= fast_paddr;
                            rsp_uncached <= fast_uncached;
                            rsp_fault    <= fast_fault;
                        end
`ifdef ADDR_TRANS_PGMAP_EN
                        else begin
                            state <= TLB_REQ;
                        end
`endif
                    end else if ((state == RESP) && rsp_ready) begin
                        state <= IDLE;
                    end
                end
`ifdef ADDR_TRANS_PGMAP_EN
                TLB_REQ: begin
                    if (tlb_grant) begin
                        state <= TLB_WAIT;
                    end
                end
                TLB_WAIT: begin
                    if (tlb_done) begin
                        state        <= RESP;
                        rsp_paddr    <= tlb_hit ? {tlb_ppn, vaddr_p0[PG_W-1:0]} : '0;
                        rsp_uncached <= tlb_hit && (tlb_mat == 2'b00);
                        rsp_fault    <= !tlb_hit;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/addr_trans_mc.sv
// Multi-channel address translation top: channel array, TLB round-robin arbiter, outstanding query.
// Define ADDR_TRANS_PGMAP_EN to build the page-mapped TLB path; otherwise DMW misses fault.
module addr_trans_mc
    import addr_trans_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int PG_W   = 12,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int VPN_W  = 32 - PG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                csr_da,
    input  logic                csr_pg,
    input  logic [1:0]          csr_plv,
    input  logic [31:0]         csr_dmw0,
    input  logic [31:0]         csr_dmw1,
    input  logic [NUM_CH*2-1:0] csr_dat,
    input  logic [NUM_CH-1:0]   req_valid,
    output logic [NUM_CH-1:0]   req_ready,
    input  logic [NUM_CH*32-1:0] req_vaddr,
    output logic [NUM_CH-1:0]   rsp_valid,
    input  logic [NUM_CH-1:0]   rsp_ready,
    output logic [NUM_CH*32-1:0] rsp_paddr,
    output logic [NUM_CH-1:0]   rsp_uncached,
    output logic [NUM_CH-1:0]   rsp_fault,
    output logic                tlb_req_valid,
    input  logic                tlb_req_ready,
    output logic [VPN_W-1:0]    tlb_req_vpn,
    output logic [CH_W-1:0]     tlb_req_ch,
    input  logic                tlb_rsp_valid,
    input  logic                tlb_rsp_hit,
    input  logic [VPN_W-1:0]    tlb_rsp_ppn,
    input  logic [1:0]          tlb_rsp_mat
);

    logic [NUM_CH-1:0]             ch_pend;
    logic [NUM_CH-1:0][VPN_W-1:0]  ch_vpn;
    logic [NUM_CH-1:0]             ch_grant;
    logic [NUM_CH-1:0]             ch_done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        addr_trans_ch #(
            .PG_W(PG_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .csr_da       (csr_da),
            .csr_pg       (csr_pg),
            .csr_plv      (csr_plv),
            .csr_dmw0     (csr_dmw0),
            .csr_dmw1     (csr_dmw1),
            .csr_dat      (csr_dat[2*i +: 2]),
            .req_valid    (req_valid[i]),
            .req_ready    (req_ready[i]),
            .req_vaddr    (req_vaddr[32*i +: 32]),
            .rsp_valid    (rsp_valid[i]),
            .rsp_ready    (rsp_ready[i]),
            .rsp_paddr    (rsp_paddr[32*i +: 32]),
            .rsp_uncached (rsp_uncached[i]),
            .rsp_fault    (rsp_fault[i]),
            .tlb_pend     (ch_pend[i]),
            .tlb_vpn      (ch_vpn[i]),
            .tlb_grant    (ch_grant[i]),
            .tlb_done     (ch_done[i]),
            .tlb_hit      (tlb_rsp_hit),
            .tlb_ppn      (tlb_rsp_ppn),
            .tlb_mat      (tlb_rsp_mat)
        );
    end

`ifdef ADDR_TRANS_PGMAP_EN
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] lock_ch;
    logic [CH_W-1:0] out_ch;
    logic [CH_W-1:0] pick_ch;
    logic [CH_W-1:0] pick_idx;
    logic [CH_W-1:0] sel_ch;
    logic [CH_W-1:0] rr_next;
    logic            lock_vld;
    logic            outstanding;
    logic            pick_vld;
    logic            grant;

    // Scan from the far end back to rr_ptr so the nearest pending channel wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        pick_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pick_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (ch_pend[pick_idx]) begin
                pick_vld = 1'b1;
                pick_ch  = pick_idx;
            end
        end
    end

    // A presented but unaccepted query is locked so valid/vpn/ch stay stable.
    assign sel_ch        = lock_vld ? lock_ch : pick_ch;
    assign tlb_req_valid = !outstanding && (lock_vld || pick_vld);
    assign tlb_req_ch    = tlb_req_valid ? sel_ch : '0;
    assign tlb_req_vpn   = tlb_req_valid ? ch_vpn[sel_ch] : '0;
    assign grant         = tlb_req_valid && tlb_req_ready;
    assign rr_next       = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;

    always_comb begin
        ch_grant = '0;
        ch_done  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_grant[i] = grant && (sel_ch == CH_W'(i));
            ch_done[i]  = tlb_rsp_valid && outstanding && (out_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            lock_vld    <= 1'b0;
            lock_ch     <= '0;
            outstanding <= 1'b0;
            out_ch      <= '0;
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                out_ch      <= sel_ch;
                lock_vld    <= 1'b0;
                rr_ptr      <= rr_next;
            end else if (tlb_req_valid) begin
                lock_vld <= 1'b1;
                lock_ch  <= sel_ch;
            end
            if (tlb_rsp_valid && outstanding) begin
                outstanding <= 1'b0;
            end
        end
    end
`else
    logic unused_tlb;

    assign tlb_req_valid = 1'b0;
    assign tlb_req_vpn   = '0;
    assign tlb_req_ch    = '0;
    assign ch_grant      = '0;
    assign ch_done       = '0;
    assign unused_tlb    = ^{tlb_req_ready, tlb_rsp_valid, tlb_rsp_hit, tlb_rsp_ppn,
                             tlb_rsp_mat, ch_pend, ch_vpn};
`endif

endmodule

// File: tb/tb_addr_trans_mc.sv
// Directed testbench for addr_trans_mc (2 channels, 4 KiB pages); TLB scenarios follow ADDR_TRANS_PGMAP_EN.
module tb_addr_trans_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_da;
    logic        csr_pg;
    logic [1:0]  csr_plv;
    logic [31:0] csr_dmw0;
    logic [31:0] csr_dmw1;
    logic [3:0]  csr_dat;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_vaddr;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_paddr;
    logic [1:0]  rsp_uncached;
    logic [1:0]  rsp_fault;
    logic        tlb_req_valid;
    logic        tlb_req_ready;
    logic [19:0] tlb_req_vpn;
    logic [0:0]  tlb_req_ch;
    logic        tlb_rsp_valid;
    logic        tlb_rsp_hit;
    logic [19:0] tlb_rsp_ppn;
    logic [1:0]  tlb_rsp_mat;

    int total = 0;
    int bad   = 0;
    bit tlb_seen = 1'b0;

    addr_trans_mc #(.NUM_CH(2), .PG_W(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .csr_da        (csr_da),
        .csr_pg        (csr_pg),
        .csr_plv       (csr_plv),
        .csr_dmw0      (csr_dmw0),
        .csr_dmw1      (csr_dmw1),
        .csr_dat       (csr_dat),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vaddr     (req_vaddr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_paddr     (rsp_paddr),
        .rsp_uncached  (rsp_uncached),
        .rsp_fault     (rsp_fault),
        .tlb_req_valid (tlb_req_valid),
        .tlb_req_ready (tlb_req_ready),
        .tlb_req_vpn   (tlb_req_vpn),
        .tlb_req_ch    (tlb_req_ch),
        .tlb_rsp_valid (tlb_rsp_valid),
        .tlb_rsp_hit   (tlb_rsp_hit),
        .tlb_rsp_ppn   (tlb_rsp_ppn),
        .tlb_rsp_mat   (tlb_rsp_mat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tlb_req_valid === 1'b1) tlb_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        csr_da        = 1'b0;
        csr_pg        = 1'b0;
        csr_plv       = 2'd0;
        csr_dmw0      = 32'h0;
        csr_dmw1      = 32'h0;
        csr_dat       = 4'h0;
        req_valid     = 2'b00;
        req_vaddr     = 64'h0;
        rsp_ready     = 2'b11;
        tlb_req_ready = 1'b1;
        tlb_rsp_valid = 1'b0;
        tlb_rsp_hit   = 1'b0;
        tlb_rsp_ppn   = 20'h0;
        tlb_rsp_mat   = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        total++;
        if (req_ready !== 2'b11) begin bad++; $display("FAIL reset_req_ready got=%b want=11", req_ready); end
        total++;
        if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
        total++;
        if (tlb_req_valid !== 1'b0) begin bad++; $display("FAIL reset_tlb_req_valid got=%b want=0", tlb_req_valid); end
        total++;
        if ({rsp_paddr, rsp_uncached, rsp_fault} !== 68'h0) begin
            bad++; $display("FAIL reset_rsp_data got=%h/%b/%b want=0", rsp_paddr, rsp_uncached, rsp_fault);
        end
        total++;
        if ({tlb_req_vpn, tlb_req_ch} !== 21'h0) begin
            bad++; $display("FAIL reset_tlb_req got=%h/%b want=0", tlb_req_vpn, tlb_req_ch);
        end
        reset = 1'b1;
        step();
        total++;
        if (req_ready !== 2'b11 || rsp_valid !== 2'b00) begin
            bad++; $display("FAIL post_reset got=%b/%b want=11/00", req_ready, rsp_valid);
        end
    endtask

    task automatic test_direct();
        do_reset();
        csr_da    = 1'b1;
        csr_dat   = 4'b0001;
        req_vaddr = {32'hA000_0040, 32'h1C00_0000};
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid !== 2'b11) begin bad++; $display("FAIL da_rsp_valid got=%b want=11", rsp_valid); end
        total++;
        if (rsp_paddr !== 64'hA000_0040_1C00_0000) begin bad++; $display("FAIL da_paddr got=%h want=a00000401c000000", rsp_paddr); end
        total++;
        if ({rsp_uncached, rsp_fault} !== 4'b1000) begin
            bad++; $display("FAIL da_flags got=%b/%b want=10/00", rsp_uncached, rsp_fault);
        end
        step();
        total++;
        if (rsp_valid !== 2'b00) begin bad++; $display("FAIL da_rsp_drop got=%b want=00", rsp_valid); end
        // da=0, pg=0 and da=1, pg=1 are both direct even with a matching window configured
        csr_dmw0  = 32'h9000_0011;
        csr_da    = 1'b0;
        csr_pg    = 1'b0;
        req_vaddr = {32'h0, 32'h9000_1234};
        req_valid = 2'b01;
        step();
        total++;
        if (rsp_paddr[31:0] !== 32'h9000_1234 || rsp_uncached[0] !== 1'b0) begin
            bad++; $display("FAIL da0pg0_direct got=%h/%b want=90001234/0", rsp_paddr[31:0], rsp_uncached[0]);
        end
        csr_da    = 1'b1;
        csr_pg    = 1'b1;
        req_vaddr = {32'h0, 32'h9000_5678};
        step();
        total++;
        if (rsp_valid[0] !== 1'b1 || rsp_paddr[31:0] !== 32'h9000_5678) begin
            bad++; $display("FAIL da1pg1_direct got=%b/%h want=1/90005678", rsp_valid[0], rsp_paddr[31:0]);
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        csr_da    = 1'b1;
        csr_dat   = 4'b0000;
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            req_vaddr = {32'h0, 32'h0000_1000 + 32'(i * 4)};
            step();
            total++;
            if (rsp_valid[0] !== 1'b1 || rsp_paddr[31:0] !== 32'h0000_1000 + 32'(i * 4) || rsp_uncached[0] !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d got=%b/%h/%b want=1/%h/1", i, rsp_valid[0], rsp_paddr[31:0],
                                rsp_uncached[0], 32'h0000_1000 + 32'(i * 4));
            end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_dmw();
        do_reset();
        csr_pg    = 1'b1;
        csr_plv   = 2'd0;
        csr_dmw0  = 32'h9000_0011;
        csr_dmw1  = 32'hA200_0009;
        req_vaddr = {32'hA000_0100, 32'h9000_1234};
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid !== 2'b11 || rsp_paddr !== 64'h2000_0100_1000_1234) begin
            bad++; $display("FAIL dmw_paddr got=%b/%h want=11/2000010010001234", rsp_valid, rsp_paddr);
        end
        total++;
        if ({rsp_uncached, rsp_fault} !== 4'b1000) begin
            bad++; $display("FAIL dmw_flags got=%b/%b want=10/00", rsp_uncached, rsp_fault);
        end
        step();
        csr_dmw1  = 32'h8200_0009;
        req_vaddr = {32'h0, 32'h9000_1234};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_paddr[31:0] !== 32'h1000_1234) begin
            bad++; $display("FAIL dmw_priority got=%h want=10001234", rsp_paddr[31:0]);
        end
        step();
        csr_dmw1  = 32'hA200_0009;
        csr_plv   = 2'd3;
        req_vaddr = {32'hA000_0100, 32'h0};
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid[1] !== 1'b1 || rsp_paddr[63:32] !== 32'h2000_0100 || rsp_uncached[1] !== 1'b1) begin
            bad++; $display("FAIL dmw_plv3 got=%b/%h/%b want=1/20000100/1", rsp_valid[1], rsp_paddr[63:32], rsp_uncached[1]);
        end
        step();
        csr_plv   = 2'd1;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
`ifdef ADDR_TRANS_PGMAP_EN
        total++;
        if (rsp_valid[1] !== 1'b0 || tlb_req_valid !== 1'b1 || tlb_req_vpn !== 20'hA0000) begin
            bad++; $display("FAIL dmw_plv1_miss got=%b/%b/%h want=0/1/a0000", rsp_valid[1], tlb_req_valid, tlb_req_vpn);
        end
`else
        total++;
        if (rsp_valid[1] !== 1'b1 || rsp_fault[1] !== 1'b1 || rsp_paddr[63:32] !== 32'h0) begin
            bad++; $display("FAIL dmw_plv1_miss got=%b/%b/%h want=1/1/0", rsp_valid[1], rsp_fault[1], rsp_paddr[63:32]);
        end
`endif
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        csr_da    = 1'b1;
        csr_dat   = 4'b0101;
        rsp_ready = 2'b10;
        req_vaddr = {32'h0, 32'h1C00_0010};
        req_valid = 2'b01;
        step();
        req_vaddr = {32'h0, 32'h1C00_0020};
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rsp_valid[0] !== 1'b1 || rsp_paddr[31:0] !== 32'h1C00_0010 || req_ready[0] !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got=%b/%h/%b want=1/1c000010/0", i, rsp_valid[0],
                                rsp_paddr[31:0], req_ready[0]);
            end
            step();
        end
        rsp_ready = 2'b11;
        #1;
        total++;
        if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", req_ready[0]); end
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid[0] !== 1'b1 || rsp_paddr[31:0] !== 32'h1C00_0020) begin
            bad++; $display("FAIL bp_next_req got=%b/%h want=1/1c000020", rsp_valid[0], rsp_paddr[31:0]);
        end
        step();
        total++;
        if (rsp_valid !== 2'b00) begin bad++; $display("FAIL bp_drain got=%b want=00", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
`ifdef ADDR_TRANS_PGMAP_EN
        csr_pg    = 1'b1;
        csr_plv   = 2'd3;
        csr_dmw0  = 32'h9000_0011;
        req_vaddr = {32'h0, 32'h9000_1234};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
`else
        csr_da    = 1'b1;
        rsp_ready = 2'b00;
        req_vaddr = {32'h0, 32'h1C00_0000};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
`endif
        reset = 1'b0;
        #2;
        reset = 1'b1;
        rsp_ready     = 2'b11;
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b1;
        tlb_rsp_ppn   = 20'h11111;
        step();
        tlb_rsp_valid = 1'b0;
        step();
        total++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b11) begin
            bad++; $display("FAIL reset_mid got=%b/%b want=00/11", rsp_valid, req_ready);
        end
        total++;
        if (tlb_req_valid !== 1'b0 || rsp_paddr !== 64'h0) begin
            bad++; $display("FAIL reset_mid_clear got=%b/%h want=0/0", tlb_req_valid, rsp_paddr);
        end
    endtask

`ifdef ADDR_TRANS_PGMAP_EN
    task automatic test_tlb_query();
        do_reset();
        csr_pg        = 1'b1;
        csr_plv       = 2'd3;
        csr_dmw0      = 32'h9000_0011;
        tlb_req_ready = 1'b0;
        req_vaddr     = {32'h0, 32'h9000_1234};
        req_valid     = 2'b01;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tlb_req_valid !== 1'b1 || tlb_req_vpn !== 20'h90001 || tlb_req_ch !== 1'b0 || rsp_valid !== 2'b00) begin
                bad++; $display("FAIL tlb_req_hold_%0d got=%b/%h/%b/%b want=1/90001/0/00", i, tlb_req_valid,
                                tlb_req_vpn, tlb_req_ch, rsp_valid);
            end
            if (i < 2) step();
        end
        tlb_req_ready = 1'b1;
        step();
        total++;
        if (tlb_req_valid !== 1'b0) begin bad++; $display("FAIL tlb_outstanding got=%b want=0", tlb_req_valid); end
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b1;
        tlb_rsp_ppn   = 20'h00ABC;
        tlb_rsp_mat   = 2'b00;
        step();
        tlb_rsp_valid = 1'b0;
        total++;
        if (rsp_valid[0] !== 1'b1 || rsp_paddr[31:0] !== 32'h00AB_C234 || rsp_uncached[0] !== 1'b1 || rsp_fault[0] !== 1'b0) begin
            bad++; $display("FAIL tlb_hit_rsp got=%b/%h/%b/%b want=1/00abc234/1/0", rsp_valid[0], rsp_paddr[31:0],
                            rsp_uncached[0], rsp_fault[0]);
        end
        step();
    endtask

    task automatic test_tlb_two_miss();
        do_reset();
        csr_pg    = 1'b1;
        csr_plv   = 2'd0;
        csr_dmw0  = 32'h9000_0011;
        csr_dmw1  = 32'hA200_0009;
        req_vaddr = {32'h0000_0678, 32'h0000_0678};
        req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        total++;
        if (tlb_req_valid !== 1'b1 || tlb_req_ch !== 1'b0 || tlb_req_vpn !== 20'h0) begin
            bad++; $display("FAIL two_miss_first got=%b/%b/%h want=1/0/0", tlb_req_valid, tlb_req_ch, tlb_req_vpn);
        end
        step();
        total++;
        if (tlb_req_valid !== 1'b0) begin bad++; $display("FAIL two_miss_blocked got=%b want=0", tlb_req_valid); end
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b1;
        tlb_rsp_ppn   = 20'h12345;
        tlb_rsp_mat   = 2'b01;
        step();
        tlb_rsp_valid = 1'b0;
        total++;
        if (rsp_valid !== 2'b01 || rsp_paddr[31:0] !== 32'h1234_5678 || rsp_uncached[0] !== 1'b0 || rsp_fault[0] !== 1'b0) begin
            bad++; $display("FAIL two_miss_ch0 got=%b/%h/%b/%b want=01/12345678/0/0", rsp_valid, rsp_paddr[31:0],
                            rsp_uncached[0], rsp_fault[0]);
        end
        total++;
        if (tlb_req_valid !== 1'b1 || tlb_req_ch !== 1'b1) begin
            bad++; $display("FAIL two_miss_second got=%b/%b want=1/1", tlb_req_valid, tlb_req_ch);
        end
        step();
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b0;
        step();
        tlb_rsp_valid = 1'b0;
        total++;
        if (rsp_valid !== 2'b10 || rsp_fault[1] !== 1'b1 || rsp_paddr[63:32] !== 32'h0 || rsp_uncached[1] !== 1'b0) begin
            bad++; $display("FAIL two_miss_ch1 got=%b/%b/%h/%b want=10/1/0/0", rsp_valid, rsp_fault[1],
                            rsp_paddr[63:32], rsp_uncached[1]);
        end
        step();
    endtask
`else
    task automatic test_nopgmap();
        do_reset();
        csr_pg        = 1'b1;
        csr_plv       = 2'd0;
        csr_dmw0      = 32'h9000_0011;
        csr_dmw1      = 32'hA200_0009;
        tlb_rsp_valid = 1'b1;
        tlb_rsp_hit   = 1'b1;
        tlb_rsp_ppn   = 20'h12345;
        req_vaddr     = {32'h0000_0678, 32'h0000_0678};
        req_valid     = 2'b11;
        step();
        req_valid     = 2'b00;
        tlb_rsp_valid = 1'b0;
        total++;
        if (rsp_valid !== 2'b11 || rsp_fault !== 2'b11) begin
            bad++; $display("FAIL nopg_fault got=%b/%b want=11/11", rsp_valid, rsp_fault);
        end
        total++;
        if (rsp_paddr !== 64'h0 || rsp_uncached !== 2'b00) begin
            bad++; $display("FAIL nopg_paddr got=%h/%b want=0/00", rsp_paddr, rsp_uncached);
        end
        step();
        total++;
        if (tlb_seen !== 1'b0) begin bad++; $display("FAIL nopg_tlb_quiet got=%b want=0", tlb_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_dmw();
        test_backpressure();
`ifdef ADDR_TRANS_PGMAP_EN
        test_tlb_query();
        test_tlb_two_miss();
`else
        test_nopgmap();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
